fma16_arbiter: RTL and testbench
================================

// Module: fma16_arbiter
// PURPOSE
//   Shares one combinational half-precision FMA datapath (fma16) between NREQ requesters.
//   Round-robin arbitration; one operation in flight at a time.
//   Operands are registered before the datapath. The result and flags are registered after it.
//   A multicycle allowance (EXEC_CYCLES) lets fma16 close timing as a multicycle path.
//   Sits between issue logic (valid/ready per requester) and a single tagged response channel.
// PARAMETERS
//   NREQ         4   number of requesters, 2..8
//   EXEC_CYCLES  1   cycles the registered operands are held on fma16 before capture, 1..15
//   IDW          $clog2(NREQ)   response tag width (derived localparam)
// PORTS
//   clk           in   1          clock, rising edge
//   reset         in   1          asynchronous reset, active-high
//   req_valid     in   NREQ       requester i has an op
//   req_ready     out  NREQ       one-hot grant; handshake = valid&ready at edge
//   req_x         in   16*NREQ    operand x, slice i = [16i+15:16i]; likewise y, z
//   req_y, req_z  in   16*NREQ    operands y, z
//   req_ctl       in   6*NREQ     slice i = {mul, add, negp, negz, roundmode[1:0]}
//   rsp_valid     out  1          result available
//   rsp_ready     in   1          consumer accepts result
//   rsp_id        out  IDW        index of the requester that issued the op
//   rsp_result    out  16         fma16 result
//   rsp_flags     out  4          {invalid, overflow, underflow, inexact}
//   busy          out  1          state != IDLE
// BEHAVIOUR
//   Reset (async): state=IDLE, rr_ptr=0, cnt=0, operand/ctl regs=0.
//     rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0.
//     Reset mid-operation drops the op silently; no response is produced.
//   FSM states: IDLE, EXEC, RESP.
//   IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     req_ready=onehot(winner), decoded combinationally from req_valid; all zero if none valid.
//     On handshake: latch x/y/z/ctl of the winner and id=winner.
//     Same edge: rr_ptr=(winner+1) mod NREQ, cnt=EXEC_CYCLES-1, go to EXEC.
//   EXEC: req_ready=0; the latched regs drive fma16.
//     cnt!=0: cnt-- each cycle.
//     cnt==0: capture fma16 result/flags into rsp regs, rsp_valid<=1, go to RESP.
//   RESP: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready.
//     On that edge: rsp_valid<=0, go to IDLE.
//     rsp_ready held low stalls indefinitely; no new grants are issued while stalled.
//   Latency: rsp_valid rises EXEC_CYCLES edges after the accept edge.
//     Minimum issue interval is EXEC_CYCLES+2 cycles.
//   Fairness: with all requesters valid, grants go ptr, ptr+1, ...
//     Each requester is granted once per NREQ ops.
//   req_valid dropping without a handshake is legal and causes no grant.
//     Operands are sampled only at the handshake edge.
//   rr_ptr changes only on a handshake.
//   rsp_id wraps naturally within IDW bits. NREQ not a power of 2: ids >= NREQ never occur.
// CONFIGURATION
//   FMA16_ARB_STICKY_EN defined:
//     adds ports sticky_flags out 4 and sticky_clr in 1.
//     sticky_flags |= rsp_flags at each response handshake edge; reset value 0.
//     sticky_clr=1 clears it next edge.
//     Simultaneous clr and handshake: result = that op's rsp_flags only (clr has priority over old bits).
//   FMA16_ARB_STICKY_EN undefined: the ports and register are absent; all other behaviour is identical.
// TESTING
//   1) Single op.
//      req_valid=0001, x=3C00 y=4000 z=4200, mul=1 add=1, rne.
//      -> rsp_valid EXEC_CYCLES edges after accept; rsp_result=4500, rsp_flags=0000, rsp_id=0.
//   2) Round robin.
//      req_valid=1111 held, rsp_ready=1, NREQ=4.
//      -> rsp_id sequence 0,1,2,3,0,...; interval EXEC_CYCLES+2 cycles.
//   3) Backpressure.
//      rsp_ready=0 for 10 cycles in RESP, req_valid=0010.
//      -> rsp_* stable, req_ready=0000 throughout; grant 1 only after rsp_ready=1.
//   4) Special cases.
//      x=7BFF y=7BFF mul=1 add=0 -> rsp_result=7C00, flags=0101.
//      x=7C00 y=0000 -> rsp_result=7E00, flags=1000.
//   5) Reset mid-EXEC with EXEC_CYCLES=4.
//      Assert reset at cnt=2 -> immediately rsp_valid=0, busy=0.
//      After release: no stale response; next grant goes to requester 0.
//   6) Sticky (FMA16_ARB_STICKY_EN).
//      Run the test 4 overflow op -> sticky_flags=0101.
//      Then the invalid op -> 1101.
//      Then sticky_clr with the test 1 handshake -> 0000.

Source files
------------

// File: rtl/fma16_arbiter.sv
// Round-robin arbiter sharing one combinational half-precision FMA (fma16) between NREQ requesters.
// Optional sticky flag accumulator enabled by defining FMA16_ARB_STICKY_EN.

module fma16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam int W = 81;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RM  = 2'b10;
    localparam logic [1:0] RM_RP  = 2'b11;

    logic [15:0] ya, za;
    logic        x_inf, x_nan, x_zero, y_inf, y_nan, y_zero, z_inf, z_nan, snan;
    logic        ps, zs, rs;
    logic [21:0] mx, my, prod;
    logic [W-1:0] mag_p, mag_z, sum;
    int unsigned sh_p, sh_z, lead, lp;
    logic [9:0]  frac;
    logic        guard, sticky, inexact, inc, ovf, to_inf;
    logic [14:0] base;
    logic [15:0] enc;

    function automatic int unsigned eff_exp(input logic [15:0] v);
        eff_exp = {27'b0, v[14:10]};
        if (v[14:10] == 5'd0) eff_exp = 32'd1;
    endfunction

    always_comb begin
        ya     = mul ? y : 16'h3C00;
        za     = add ? z : 16'h0000;
        x_inf  = (&x[14:10]) & ~(|x[9:0]);
        x_nan  = (&x[14:10]) & (|x[9:0]);
        x_zero = ~(|x[14:0]);
        y_inf  = (&ya[14:10]) & ~(|ya[9:0]);
        y_nan  = (&ya[14:10]) & (|ya[9:0]);
        y_zero = ~(|ya[14:0]);
        z_inf  = (&za[14:10]) & ~(|za[9:0]);
        z_nan  = (&za[14:10]) & (|za[9:0]);
        snan   = (x_nan & ~x[9]) | (y_nan & ~ya[9]) | (z_nan & ~za[9]);
        ps     = x[15] ^ ya[15] ^ negp;
        zs     = za[15] ^ negz;

        // Exact sum in a fixed-point field whose LSB weighs 2^-48.
        mx    = {11'b0, |x[14:10], x[9:0]};
        my    = {11'b0, |ya[14:10], ya[9:0]};
        prod  = mx * my;
        sh_p  = eff_exp(x) + eff_exp(ya) - 32'd2;
        sh_z  = eff_exp(za) + 32'd23;
        mag_p = {{(W-22){1'b0}}, prod} << sh_p;
        mag_z = {{(W-11){1'b0}}, |za[14:10], za[9:0]} << sh_z;

        if (ps == zs) begin
            sum = mag_p + mag_z;
            rs  = ps;
        end else if (mag_p >= mag_z) begin
            sum = mag_p - mag_z;
            rs  = ps;
        end else begin
            sum = mag_z - mag_p;
            rs  = zs;
        end
        if (sum == '0) rs = (ps == zs) ? ps : (roundmode == RM_RM);

        lead = 0;
        for (int unsigned i = 0; i < W; i++) begin
            if ((sum & (ONE << i)) != '0) lead = i;
        end

        // Bit 34 is 2^-14, the smallest normal; below it the quantum is fixed at 2^-24 (bit 24).
        lp      = (lead >= 32'd34) ? lead - 32'd10 : 32'd24;
        frac    = 10'(sum >> lp);
        guard   = (sum & (ONE << (lp - 32'd1))) != '0;
        sticky  = (sum & ((ONE << (lp - 32'd1)) - ONE)) != '0;
        inexact = guard | sticky;
        case (roundmode)
            RM_RNE:  inc = guard & (sticky | frac[0]);
            RM_RM:   inc = rs & inexact;
            RM_RP:   inc = ~rs & inexact;
            default: inc = 1'b0;
        endcase

        // Rounding carry ripples from fraction into exponent, covering subnormal->normal too.
        base   = (lead >= 32'd34) ? {5'(lead - 32'd33), frac} : {5'b0, frac};
        enc    = {1'b0, base} + {15'b0, inc};
        ovf    = (lead >= 32'd64) | (enc >= 16'h7C00);
        to_inf = (roundmode == RM_RNE) | ((roundmode == RM_RP) & ~rs) | ((roundmode == RM_RM) & rs);

        result = {rs, enc[14:0]};
        flags  = {2'b00, inexact & (lead < 32'd34), inexact};
        if (ovf) begin
            result = to_inf ? {rs, 15'h7C00} : {rs, 15'h7BFF};
            flags  = 4'b0101;
        end

        if (x_nan | y_nan | z_nan) begin
            result = 16'h7E00;
            flags  = {snan, 3'b000};
        end else if ((x_inf & y_zero) | (x_zero & y_inf) | ((x_inf | y_inf) & z_inf & (ps != zs))) begin
            result = 16'h7E00;
            flags  = 4'b1000;
        end else if (x_inf | y_inf) begin
            result = {ps, 15'h7C00};
            flags  = 4'b0000;
        end else if (z_inf) begin
            result = {zs, 15'h7C00};
            flags  = 4'b0000;
        end
    end
endmodule

module fma16_arbiter #(
    parameter int NREQ        = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [16*NREQ-1:0]  req_x,
    input  logic [16*NREQ-1:0]  req_y,
    input  logic [16*NREQ-1:0]  req_z,
    input  logic [6*NREQ-1:0]   req_ctl,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]         rsp_result,
    output logic [3:0]          rsp_flags,
    output logic                busy
`ifdef FMA16_ARB_STICKY_EN
    ,
    output logic [3:0]          sticky_flags,
    input  logic                sticky_clr
`endif
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [5:0]      ctl_q, ctl_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic [15:0]     fma_result;
    logic [3:0]      fma_flags;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    int unsigned     idx;

    fma16 u_fma16 (
        .x         (x_q),
        .y         (y_q),
        .z         (z_q),
        .mul       (ctl_q[5]),
        .add       (ctl_q[4]),
        .negp      (ctl_q[3]),
        .negz      (ctl_q[2]),
        .roundmode (ctl_q[1:0]),
        .result    (fma_result),
        .flags     (fma_flags)
    );

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_found && ((req_valid & (NREQ'(1) << idx)) != '0)) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        ctl_d        = ctl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready = NREQ'(1) << win_idx;
                    x_d       = 16'(req_x >> (16 * win_idx));
                    y_d       = 16'(req_y >> (16 * win_idx));
                    z_d       = 16'(req_z >> (16 * win_idx));
                    ctl_d     = 6'(req_ctl >> (6 * win_idx));
                    id_d      = win_idx;
                    rr_ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    cnt_d     = 4'(EXEC_CYCLES - 1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = fma_result;
                    rsp_flags_d  = fma_flags;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            ctl_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            ctl_q        <= ctl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);

`ifdef FMA16_ARB_STICKY_EN
    logic [3:0] sticky_q, sticky_d;

    // Clear drops only the old bits; a same-edge response still lands.
    always_comb begin
        sticky_d = sticky_clr ? 4'b0000 : sticky_q;
        if ((state_q == RESP) && rsp_ready) sticky_d = sticky_d | rsp_flags_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sticky_q <= '0;
        else       sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed self-checking bench for fma16_arbiter (NREQ=4, EXEC_CYCLES=4).
// Sticky-flag steps compile only when FMA16_ARB_STICKY_EN is defined.

module tb_fma16_arbiter;
    localparam int NREQ        = 4;
    localparam int EXEC_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_x, req_y, req_z;
    logic [23:0] req_ctl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
`ifdef FMA16_ARB_STICKY_EN
    logic [3:0]  sticky_flags;
    logic        sticky_clr;
`endif

    int n_vec = 0;
    int n_err = 0;

    fma16_arbiter #(.NREQ(NREQ), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_z      (req_z),
        .req_ctl    (req_ctl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
`ifdef FMA16_ARB_STICKY_EN
        ,
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic [5:0] ctl);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_z[16*i +: 16] = z;
        req_ctl[6*i +: 6] = ctl;
    endtask

    // One complete transaction with rsp_ready high: grant, EXEC wait, response, handshake.
    task automatic run_op(input string tag, input logic [3:0] vmask, input int exp_id,
                          input logic [15:0] exp_res, input logic [3:0] exp_flags,
                          input bit keep, input bit clr);
        req_valid = vmask;
        #1;
        chk({tag, "/grant"}, {28'b0, req_ready}, 32'(1) << exp_id);
        tick();
        if (!keep) req_valid = 4'b0000;
        chk({tag, "/busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "/early"}, {31'b0, rsp_valid}, 32'd0);
        for (int c = 1; c < EXEC_CYCLES; c++) begin
            tick();
            chk({tag, "/wait"}, {31'b0, rsp_valid}, 32'd0);
        end
        tick();
        chk({tag, "/valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "/id"}, {30'b0, rsp_id}, 32'(exp_id));
        chk({tag, "/result"}, {16'b0, rsp_result}, {16'b0, exp_res});
        chk({tag, "/flags"}, {28'b0, rsp_flags}, {28'b0, exp_flags});
`ifdef FMA16_ARB_STICKY_EN
        sticky_clr = clr;
`endif
        tick();
`ifdef FMA16_ARB_STICKY_EN
        sticky_clr = 1'b0;
`endif
        chk({tag, "/done"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "/idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        req_ctl   = '0;
        rsp_ready = 1'b1;
`ifdef FMA16_ARB_STICKY_EN
        sticky_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst/valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst/id", {30'b0, rsp_id}, 32'd0);
        chk("rst/result", {16'b0, rsp_result}, 32'd0);
        chk("rst/flags", {28'b0, rsp_flags}, 32'd0);
        chk("rst/busy", {31'b0, busy}, 32'd0);
        chk("rst/ready", {28'b0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();

        // Round robin: requester i computes (i+1)*2.
        set_req(0, 16'h3C00, 16'h4000, 16'h0000, 6'h21);
        set_req(1, 16'h4000, 16'h4000, 16'h0000, 6'h21);
        set_req(2, 16'h4200, 16'h4000, 16'h0000, 6'h21);
        set_req(3, 16'h4400, 16'h4000, 16'h0000, 6'h21);
        run_op("rr0", 4'b1111, 0, 16'h4000, 4'b0000, 1'b1, 1'b0);
        run_op("rr1", 4'b1111, 1, 16'h4400, 4'b0000, 1'b1, 1'b0);
        run_op("rr2", 4'b1111, 2, 16'h4600, 4'b0000, 1'b1, 1'b0);
        run_op("rr3", 4'b1111, 3, 16'h4800, 4'b0000, 1'b1, 1'b0);
        run_op("rr4", 4'b1111, 0, 16'h4000, 4'b0000, 1'b0, 1'b0);

        set_req(0, 16'h3C00, 16'h4000, 16'h4200, 6'h31);
        run_op("t1", 4'b0001, 0, 16'h4500, 4'b0000, 1'b0, 1'b0);

        set_req(3, 16'h3C00, 16'h4000, 16'h4200, 6'h39);
        run_op("negp", 4'b1000, 3, 16'h3C00, 4'b0000, 1'b0, 1'b0);
        set_req(3, 16'h3C00, 16'h4000, 16'h4200, 6'h35);
        run_op("negz", 4'b1000, 3, 16'hBC00, 4'b0000, 1'b0, 1'b0);
        set_req(3, 16'h4000, 16'h0000, 16'h4200, 6'h11);
        run_op("addonly", 4'b1000, 3, 16'h4500, 4'b0000, 1'b0, 1'b0);
        set_req(3, 16'h3C01, 16'h3C01, 16'h0000, 6'h21);
        run_op("rne", 4'b1000, 3, 16'h3C02, 4'b0001, 1'b0, 1'b0);
        set_req(3, 16'h3C01, 16'h3C01, 16'h0000, 6'h23);
        run_op("rp", 4'b1000, 3, 16'h3C03, 4'b0001, 1'b0, 1'b0);
        set_req(3, 16'h0001, 16'h3C00, 16'h0000, 6'h21);
        run_op("subn", 4'b1000, 3, 16'h0001, 4'b0000, 1'b0, 1'b0);
        set_req(3, 16'h0001, 16'h3800, 16'h0000, 6'h21);
        run_op("uflow", 4'b1000, 3, 16'h0000, 4'b0011, 1'b0, 1'b0);

        // Backpressure with an overflowing op held in RESP.
        set_req(1, 16'h7BFF, 16'h7BFF, 16'h0000, 6'h21);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("bp/grant", {28'b0, req_ready}, 32'h2);
        tick();
        chk("bp/busy", {31'b0, busy}, 32'd1);
        repeat (EXEC_CYCLES) tick();
        chk("bp/valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp/id", {30'b0, rsp_id}, 32'd1);
        chk("bp/result", {16'b0, rsp_result}, 32'h7C00);
        chk("bp/flags", {28'b0, rsp_flags}, 32'h5);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp/hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp/hold_result", {16'b0, rsp_result}, 32'h7C00);
            chk("bp/hold_flags", {28'b0, rsp_flags}, 32'h5);
            chk("bp/hold_ready", {28'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp/release", {31'b0, rsp_valid}, 32'd0);
        chk("bp/regrant", {28'b0, req_ready}, 32'h2);
        set_req(1, 16'h7C00, 16'h0000, 16'h0000, 6'h21);
        run_op("inv", 4'b0010, 1, 16'h7E00, 4'b1000, 1'b0, 1'b0);

        // Reset during EXEC drops the op and the round-robin pointer.
        set_req(2, 16'h3C00, 16'h4000, 16'h4200, 6'h31);
        req_valid = 4'b0100;
        #1;
        chk("mr/grant", {28'b0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        reset = 1'b1;
        #1;
        chk("mr/valid", {31'b0, rsp_valid}, 32'd0);
        chk("mr/busy", {31'b0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("mr/stale", {31'b0, rsp_valid}, 32'd0);
            chk("mr/quiet", {31'b0, busy}, 32'd0);
        end
        set_req(0, 16'h3C00, 16'h4000, 16'h4200, 6'h31);
        run_op("mr/after", 4'b1111, 0, 16'h4500, 4'b0000, 1'b0, 1'b0);

`ifdef FMA16_ARB_STICKY_EN
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("st/clear", {28'b0, sticky_flags}, 32'd0);
        set_req(1, 16'h7BFF, 16'h7BFF, 16'h0000, 6'h21);
        run_op("st/ovf", 4'b0010, 1, 16'h7C00, 4'b0101, 1'b0, 1'b0);
        chk("st/ovf_acc", {28'b0, sticky_flags}, 32'h5);
        set_req(1, 16'h7C00, 16'h0000, 16'h0000, 6'h21);
        run_op("st/inv", 4'b0010, 1, 16'h7E00, 4'b1000, 1'b0, 1'b0);
        chk("st/inv_acc", {28'b0, sticky_flags}, 32'hD);
        set_req(0, 16'h3C00, 16'h4000, 16'h4200, 6'h31);
        run_op("st/clr_hs", 4'b0001, 0, 16'h4500, 4'b0000, 1'b0, 1'b1);
        chk("st/clr_acc", {28'b0, sticky_flags}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
